// File: rtl/wrr_grant_scheduler.sv
// ============================================================================
// wrr_grant_scheduler : weighted round-robin grant scheduler with burst hold
// Revision : 1.0
// ============================================================================
`default_nettype none

module wrr_grant_scheduler #(
  parameter  int NUM_REQ  = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  last_i,
  input  logic                cfg_we_i,
  input  logic [IDX_W-1:0]    cfg_idx_i,
  input  logic [WEIGHT_W-1:0] cfg_weight_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [IDX_W-1:0]    grant_id_o,
  output logic                busy_o,
  output logic [WEIGHT_W-1:0] beat_cnt_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] beat_q, beat_d;
  logic [WEIGHT_W-1:0] len_q, len_d;
  logic                busy_q, busy_d;
  logic [WEIGHT_W-1:0] weight_q [NUM_REQ];

  logic                w_cfg_hit;
  logic                w_release;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [IDX_W-1:0]    w_start;
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_sel_idx;
  logic [WEIGHT_W-1:0] w_sel_weight;
  logic [WEIGHT_W-1:0] w_sel_len;

  assign w_cfg_hit = cfg_we_i && (int'(cfg_idx_i) < NUM_REQ);

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (reset) begin
        weight_q[k] <= WEIGHT_W'(1);
      end else if (w_cfg_hit && (cfg_idx_i == IDX_W'(k))) begin
        weight_q[k] <= cfg_weight_i;
      end
    end
  end

  // Release is decided on the pre-increment count, so beat_cnt never wraps.
  assign w_release = (state_q == HOLD) &&
                     (!req_i[owner_q] || last_i[owner_q] ||
                      ((beat_q + WEIGHT_W'(1)) == len_q));

  assign w_next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign w_start    = w_release ? w_next_ptr : ptr_q;

  // Descending scan so the requester closest to w_start is written last.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int               s;
      logic [IDX_W-1:0] idx;
      s = int'(w_start) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = IDX_W'(s);
      if (req_i[idx]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = idx;
      end
    end
  end

  // A write landing on the same edge as the grant wins over the stored weight.
  assign w_sel_weight = (w_cfg_hit && (cfg_idx_i == w_sel_idx)) ? cfg_weight_i
                                                                : weight_q[w_sel_idx];
  assign w_sel_len    = (w_sel_weight == '0) ? WEIGHT_W'(1) : w_sel_weight;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (w_sel_valid) begin
          state_d            = HOLD;
          grant_d            = '0;
          grant_d[w_sel_idx] = 1'b1;
          owner_d            = w_sel_idx;
          beat_d             = '0;
          len_d              = w_sel_len;
          busy_d             = 1'b1;
        end
      end
      HOLD: begin
        if (w_release) begin
          ptr_d  = w_next_ptr;
          beat_d = '0;
          if (w_sel_valid) begin
            grant_d            = '0;
            grant_d[w_sel_idx] = 1'b1;
            owner_d            = w_sel_idx;
            len_d              = w_sel_len;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          beat_d = beat_q + WEIGHT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      len_q   <= WEIGHT_W'(1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = owner_q;
  assign busy_o     = busy_q;
  assign beat_cnt_o = beat_q;

endmodule

`default_nettype wire

// File: tb/tb_wrr_grant_scheduler.sv
// ============================================================================
// tb_wrr_grant_scheduler : directed scoreboard bench for wrr_grant_scheduler
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wrr_grant_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic [3:0] a_req = '0, a_last = '0, a_w = '0;
  logic       a_we  = 1'b0;
  logic [1:0] a_idx = '0;
  logic [3:0] a_grant, a_beat;
  logic [1:0] a_id;
  logic       a_busy;

  logic [2:0] b_req = '0, b_last = '0;
  logic [3:0] b_w   = '0;
  logic       b_we  = 1'b0;
  logic [1:0] b_idx = '0;
  logic [2:0] b_grant;
  logic [3:0] b_beat;
  logic [1:0] b_id;
  logic       b_busy;

  wrr_grant_scheduler #(.NUM_REQ(4), .WEIGHT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .req_i(a_req), .last_i(a_last),
    .cfg_we_i(a_we), .cfg_idx_i(a_idx), .cfg_weight_i(a_w),
    .grant_o(a_grant), .grant_id_o(a_id), .busy_o(a_busy), .beat_cnt_o(a_beat)
  );

  // Three requesters: index 3 is representable but out of range.
  wrr_grant_scheduler #(.NUM_REQ(3), .WEIGHT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .req_i(b_req), .last_i(b_last),
    .cfg_we_i(b_we), .cfg_idx_i(b_idx), .cfg_weight_i(b_w),
    .grant_o(b_grant), .grant_id_o(b_id), .busy_o(b_busy), .beat_cnt_o(b_beat)
  );

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic [3:0] beat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input exp_t e, input logic [3:0] g, input logic [1:0] id,
                       input logic busy, input logic [3:0] beat);
    n_checks++;
    if ({g, id, busy, beat} !== {e.g, e.id, e.busy, e.beat}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b beat=%0d, expected grant=%b id=%0d busy=%b beat=%0d",
               e.name, g, id, busy, beat, e.g, e.id, e.busy, e.beat);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [3:0] eg,
                              input logic [1:0] eid, input logic [3:0] ebt);
    exp_t e;
    e.name = nm;
    e.g    = eg;
    e.id   = eid;
    e.busy = |eg;
    e.beat = ebt;
    return e;
  endfunction

  // Drive one cycle of stimulus to DUT A; expectation is the state after the next edge.
  task automatic sa(input string nm, input logic rst, input logic [3:0] r, input logic [3:0] l,
                    input logic we, input logic [1:0] idx, input logic [3:0] w,
                    input logic [3:0] eg, input logic [1:0] eid, input logic [3:0] ebt);
    @(negedge clk);
    reset  = rst;
    a_req  = r;
    a_last = l;
    a_we   = we;
    a_idx  = idx;
    a_w    = w;
    qa.push_back(mk(nm, eg, eid, ebt));
  endtask

  task automatic sb(input string nm, input logic rst, input logic [2:0] r,
                    input logic we, input logic [1:0] idx, input logic [3:0] w,
                    input logic [2:0] eg, input logic [1:0] eid, input logic [3:0] ebt);
    @(negedge clk);
    reset = rst;
    b_req = r;
    b_we  = we;
    b_idx = idx;
    b_w   = w;
    qb.push_back(mk(nm, {1'b0, eg}, eid, ebt));
  endtask

  initial begin : mon_a
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check(e, a_grant, a_id, a_busy, a_beat);
      end
    end
  end

  initial begin : mon_b
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check(e, {1'b0, b_grant}, b_id, b_busy, b_beat);
      end
    end
  end

  initial begin : stim
    sa("reset0",     1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    sa("reset1",     1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    // sole requester re-granted every cycle with weight 1
    sa("single_c1",  0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("single_c2",  0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("single_c3",  0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("single_off", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    sa("cfg_w0_3",   0, 4'b0000, 4'b0000, 1, 0, 3, 4'b0000, 0, 0);
    sa("cfg_w2_2",   0, 4'b0000, 4'b0000, 1, 2, 2, 4'b0000, 0, 0);
    // weighted rotation {3,1,2,1}, starting at ptr=1
    sa("rot_1",      0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("rot_2a",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0100, 2, 0);
    sa("rot_2b",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0100, 2, 1);
    sa("rot_3",      0, 4'b1111, 4'b0000, 0, 0, 0, 4'b1000, 3, 0);
    sa("rot_0a",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("rot_0b",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 0, 1);
    sa("rot_0c",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 0, 2);
    sa("rot_1r",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("rot_2r",     0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0100, 2, 0);
    // idle return keeps the previous owner id
    sa("idle_hold",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 2, 0);
    sa("idle_req3",  0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0);
    sa("idle_again", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 3, 0);
    // early termination by dropping req
    sa("cfg_w2_5",   0, 4'b0000, 4'b0000, 1, 2, 5, 4'b0000, 3, 0);
    sa("drop_b0",    0, 4'b1100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0);
    sa("drop_b1",    0, 4'b1100, 4'b0000, 0, 0, 0, 4'b0100, 2, 1);
    sa("drop_b2",    0, 4'b1100, 4'b0000, 0, 0, 0, 4'b0100, 2, 2);
    sa("drop_to3",   0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0);
    sa("drop_3again",0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0);
    sa("drop_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 3, 0);
    // early termination by last
    sa("last_b0",    0, 4'b1100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0);
    sa("last_to3",   0, 4'b1100, 4'b0100, 0, 0, 0, 4'b1000, 3, 0);
    sa("last_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 3, 0);
    // weight 0 acts as 1
    sa("cfg_w1_0",   0, 4'b0000, 4'b0000, 1, 1, 0, 4'b0000, 3, 0);
    sa("w0_grant",   0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("w0_to3",     0, 4'b1010, 4'b0000, 0, 0, 0, 4'b1000, 3, 0);
    sa("w0_idle",    0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 3, 0);
    // mid-burst write only affects the following burst
    sa("cfg_w0_2",   0, 4'b0000, 4'b0000, 1, 0, 2, 4'b0000, 3, 0);
    sa("mid_b0",     0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("mid_wr4",    0, 4'b0011, 4'b0000, 1, 0, 4, 4'b0001, 0, 1);
    sa("mid_to1",    0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("new_b0",     0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("new_b1",     0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0001, 0, 1);
    sa("new_b2",     0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0001, 0, 2);
    sa("new_b3",     0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0001, 0, 3);
    sa("new_to1",    0, 4'b0011, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("new_idle",   0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    // write on the release edge of the re-granted owner takes effect immediately
    sa("rel_g",      0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("rel_wr2",    0, 4'b0010, 4'b0000, 1, 1, 2, 4'b0010, 1, 0);
    sa("rel_b1",     0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);
    sa("rel_b0",     0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("rel_idle",   0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 1, 0);
    // reset in the middle of a burst
    sa("cfg_w1_3",   0, 4'b0000, 4'b0000, 1, 1, 3, 4'b0000, 1, 0);
    sa("rst_b0",     0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("rst_b1",     0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 1);
    sa("rst_b2",     0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 2);
    sa("rst_mid",    1, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    sa("post_rst0",  0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("post_rst1",  0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0010, 1, 0);
    sa("post_rst2",  0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0100, 2, 0);
    sa("post_rst3",  0, 4'b1111, 4'b0000, 0, 0, 0, 4'b1000, 3, 0);
    sa("post_rst0b", 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 0, 0);
    sa("post_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    repeat (2) @(negedge clk);

    // out-of-range index is dropped; three-way rotation wraps mod 3
    sb("b_reset",    1, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    sb("b_bad_idx",  0, 3'b000, 1, 3, 5, 3'b000, 0, 0);
    sb("b_rot0",     0, 3'b111, 0, 0, 0, 3'b001, 0, 0);
    sb("b_rot1",     0, 3'b111, 0, 0, 0, 3'b010, 1, 0);
    sb("b_rot2",     0, 3'b111, 0, 0, 0, 3'b100, 2, 0);
    sb("b_rot0b",    0, 3'b111, 0, 0, 0, 3'b001, 0, 0);
    sb("b_idle",     0, 3'b000, 0, 0, 0, 3'b000, 0, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
